instr_mem_fetch: RTL

INSTR_MEM_FETCH -- requirements
Module: instr_mem_fetch

---
 rtl/instr_mem_fetch.sv | 123 ++++++++++++
 1 files changed

// File: rtl/instr_mem_fetch.sv
// Instruction memory with a single-outstanding fetch port and a program-load write port.
// The fetch latency is fixed by LATENCY. Faulted fetches return NOP_INSTR without reading the array.
module instr_mem_fetch #(
  parameter int DEPTH   = 256,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int LATENCY = 1,
  parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(32'h00000013)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDR_W-1:0]        req_pc,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_W-1:0]        rsp_instr,
  output logic [1:0]               rsp_fault,
  input  logic                     flush,
  input  logic                     ld_en,
  input  logic [$clog2(DEPTH)-1:0] ld_addr,
  input  logic [DATA_W-1:0]        ld_data
);

  localparam int IDX_W = $clog2(DEPTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [1:0] FAULT_OK  = 2'b00;
  localparam logic [1:0] FAULT_MIS = 2'b01;
  localparam logic [1:0] FAULT_OOR = 2'b10;

  localparam logic [ADDR_W-1:0] DEPTH_WORDS = ADDR_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [1:0]        state;
  logic [2:0]        cnt;
  logic [DATA_W-1:0] hold_instr;
  logic [1:0]        hold_fault;

  logic [IDX_W-1:0]  idx;
  logic [ADDR_W-1:0] word_addr;
  logic [1:0]        fault;
  logic [DATA_W-1:0] fetch_word;
  logic              accept;

  always_comb begin
    idx       = req_pc[IDX_W+1:2];
    word_addr = req_pc >> 2;
    fault     = FAULT_OK;
    if (req_pc[1:0] != 2'b00)
      fault = FAULT_MIS;
    else if (word_addr >= DEPTH_WORDS)
      fault = FAULT_OOR;
    fetch_word = NOP_INSTR;
    if (fault == FAULT_OK)
      fetch_word = mem[idx];
  end

  assign req_ready = (state == IDLE) && !flush && !reset;
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (state == RESP);

  // Write lands after the edge, so a same-cycle fetch of that word sees the old contents.
  always_ff @(posedge clk) begin
    if (ld_en && !reset)
      mem[ld_addr] <= ld_data;
  end

  // Response registers only change on entry to RESP so they hold between fetches.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 3'd0;
      rsp_instr  <= '0;
      rsp_fault  <= FAULT_OK;
      hold_instr <= '0;
      hold_fault <= FAULT_OK;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (LATENCY == 1) begin
              state     <= RESP;
              rsp_instr <= fetch_word;
              rsp_fault <= fault;
            end else begin
              state      <= BUSY;
              cnt        <= 3'(LATENCY - 1);
              hold_instr <= fetch_word;
              hold_fault <= fault;
            end
          end
        end
        BUSY: begin
          if (flush) begin
            state <= IDLE;
            cnt   <= 3'd0;
          end else if (cnt == 3'd1) begin
            state     <= RESP;
            cnt       <= 3'd0;
            rsp_instr <= hold_instr;
            rsp_fault <= hold_fault;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        RESP: begin
          if (flush || rsp_ready)
            state <= IDLE;
        end
        default: begin
          state <= IDLE;
          cnt   <= 3'd0;
        end
      endcase
    end
  end

endmodule
